gpio_irq_filter: RTL

GPIO_IRQ_FILTER -- requirements
Module: gpio_irq_filter

---
 rtl/gpio_irq_filter_pkg.sv | 21 ++
 rtl/gpio_bit_filter.sv | 84 ++++++++
 rtl/gpio_irq_filter.sv | 78 +++++++
 3 files changed

// File: rtl/gpio_irq_filter_pkg.sv
// Shared definitions for the GPIO interrupt filter.
//
// Holds the default pin count, the default debounce length and the helper that
// sizes each per-pin debounce counter.
package gpio_irq_filter_pkg;

  // Number of independent input pins.
  localparam int unsigned DefaultWidth = 8;

  // Synchronized cycles a pin must hold a new value before it is accepted.
  localparam int unsigned DefaultDebounceCycles = 16;

  // Counter width able to hold 0..cycles. The counter only ever reaches
  // cycles-1, but sizing for cycles keeps DEBOUNCE_CYCLES=1 at a legal 1 bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/gpio_bit_filter.sv
// Single-pin input conditioner.
//
// A two-flop synchronizer followed by a debounce counter. The accepted level
// only changes once the synchronized value has differed from it for
// DEBOUNCE_CYCLES consecutive cycles. rise/fall flag the edge on which the
// level is about to change, so the parent can capture pending bits on that
// same edge.
//
// Ports:
//   clk       - clock
//   resetn    - asynchronous active-low reset
//   pin_async - raw pad input
//   level     - debounced, registered level
//   rise      - level changes 0->1 at the next clock edge
//   fall      - level changes 1->0 at the next clock edge
module gpio_bit_filter
  import gpio_irq_filter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic pin_async,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned     CntW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q;
  logic            sync_q;
  logic            level_q;
  logic            level_d;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;
  logic            update;

  // Synchronizer: both stages reset to the level value so that reset release
  // never looks like an edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= RESET_LEVEL;
      sync_q  <= RESET_LEVEL;
    end else begin
      sync1_q <= pin_async;
      sync_q  <= sync1_q;
    end
  end

  // Debounce: count consecutive cycles of disagreement; any agreement restarts
  // the count, so short pulses leave no trace.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    update  = 1'b0;
    if (sync_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      update  = 1'b1;
      level_d = sync_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      level_q <= RESET_LEVEL;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;
  assign rise  = update & sync_q;
  assign fall  = update & ~sync_q;

endmodule

// File: rtl/gpio_irq_filter.sv
// GPIO interrupt filter.
//
// Synchronizes and debounces WIDTH asynchronous pins, then records enabled
// rising/falling level changes in sticky pending bits that software clears
// with a write-1-to-clear strobe. irq is the OR of all pending bits.
//
// Ports:
//   clk         - single clock for all state
//   resetn      - asynchronous active-low reset
//   pin_async   - raw pad inputs
//   irq_rise_en - per-bit rising-edge interrupt enable
//   irq_fall_en - per-bit falling-edge interrupt enable
//   clr_valid   - pending-clear strobe
//   clr_mask    - bits to clear, used only while clr_valid=1
//   level       - debounced pin levels
//   pending     - sticky interrupt-pending bits
//   irq         - OR-reduction of pending
module gpio_irq_filter
  import gpio_irq_filter_pkg::*;
#(
  parameter int unsigned      WIDTH           = DefaultWidth,
  parameter int unsigned      DEBOUNCE_CYCLES = DefaultDebounceCycles,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] pin_async,
  input  logic [WIDTH-1:0] irq_rise_en,
  input  logic [WIDTH-1:0] irq_fall_en,
  input  logic             clr_valid,
  input  logic [WIDTH-1:0] clr_mask,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] pending,
  output logic             irq
);

  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] set_bits;
  logic [WIDTH-1:0] clr_bits;
  logic [WIDTH-1:0] pending_q;
  logic [WIDTH-1:0] pending_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_bit_filter #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL    (RESET_LEVEL[i])
    ) u_bit (
      .clk      (clk),
      .resetn   (resetn),
      .pin_async(pin_async[i]),
      .level    (level[i]),
      .rise     (rise[i]),
      .fall     (fall[i])
    );
  end

  // Enables are only looked at on the edge where the level changes, so
  // enabling later never resurrects an old event. Set is OR-ed in after the
  // clear so a simultaneous set wins.
  always_comb begin
    clr_bits  = clr_valid ? clr_mask : '0;
    set_bits  = (rise & irq_rise_en) | (fall & irq_fall_en);
    pending_d = (pending_q & ~clr_bits) | set_bits;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;
  assign irq     = |pending_q;

endmodule
